// File: rtl/fp_pkg.sv
// Shared types for the FP result buffer: entry word and presentation states.
package fp_pkg;
  localparam int FP_FLAGS_W = 5;
  localparam int FP_DATA_W  = 32;

  typedef struct packed {
    logic [FP_FLAGS_W-1:0] flags;
    logic [FP_DATA_W-1:0]  result;
  } entry_t;

  localparam int S_EMPTY_IX   = 0;
  localparam int S_SHOW_LO_IX = 1;
  localparam int S_SHOW_HI_IX = 2;

  typedef enum logic [2:0] {
    S_EMPTY   = 3'b001,
    S_SHOW_LO = 3'b010,
    S_SHOW_HI = 3'b100
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO of fp entries with wrap-around pointers and occupancy count.
module sync_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [AW:0]   count
);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;
endmodule

// File: rtl/fp_result_buffer.sv
// Buffers adder results and steps them onto a 16-bit hex display, low half first.
// Define FP_RESULT_BUF_TOTAL_EN to add the saturating 'total' push counter.
module fp_result_buffer
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FP_DATA_W-1:0]  result,
  input  logic [FP_FLAGS_W-1:0] flags,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  step,
  output logic [15:0]           disp_data,
  output logic                  disp_hi,
  output logic [FP_FLAGS_W-1:0] disp_flags,
  output logic                  disp_en,
  output logic [AW:0]           count
`ifdef FP_RESULT_BUF_TOTAL_EN
  ,
  output logic [7:0]            total
`endif
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  state_t      state_q, state_d;
  entry_t      head, wdata;
  logic        push, pop;
  logic [AW:0] count_after;

  assign ready_out = (count != FULL);
  assign push      = valid_in & ready_out;
  assign wdata     = '{flags: flags, result: result};

  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    disp_data   = '0;
    disp_hi     = 1'b0;
    disp_flags  = '0;
    disp_en     = 1'b0;
    count_after = count - ONE + (push ? ONE : '0);
    unique case (1'b1)
      state_q[S_EMPTY_IX]: begin
        if (count != '0) state_d = S_SHOW_LO;
      end
      state_q[S_SHOW_LO_IX]: begin
        disp_data  = head.result[15:0];
        disp_flags = head.flags;
        disp_en    = 1'b1;
        if (step) state_d = S_SHOW_HI;
      end
      state_q[S_SHOW_HI_IX]: begin
        disp_data  = head.result[31:16];
        disp_flags = head.flags;
        disp_hi    = 1'b1;
        disp_en    = 1'b1;
        // a concurrent push keeps the buffer non-empty after this pop
        if (step) begin
          pop     = 1'b1;
          state_d = (count_after != '0) ? S_SHOW_LO : S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

`ifdef FP_RESULT_BUF_TOTAL_EN
  logic [7:0] total_q;

  always_ff @(posedge clk) begin
    if (rst) total_q <= '0;
    else if (push && total_q != 8'hFF) total_q <= total_q + 8'd1;
  end

  assign total = total_q;
`endif
endmodule

// File: tb/tb_fp_result_buffer.sv
// Scoreboard bench for fp_result_buffer: directed scenarios plus random traffic.
module tb_fp_result_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        valid_in;
  logic        ready_out;
  logic        step;
  logic [15:0] disp_data;
  logic        disp_hi;
  logic [4:0]  disp_flags;
  logic        disp_en;
  logic [AW:0] count;
`ifdef FP_RESULT_BUF_TOTAL_EN
  logic [7:0]  total;
`endif

  fp_result_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .result     (result),
    .flags      (flags),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .step       (step),
    .disp_data  (disp_data),
    .disp_hi    (disp_hi),
    .disp_flags (disp_flags),
    .disp_en    (disp_en),
    .count      (count)
`ifdef FP_RESULT_BUF_TOTAL_EN
    ,
    .total      (total)
`endif
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  // Reference model: queue of {flags,result} words awaiting display,
  // plus which half (if any) the display currently shows.
  bit [36:0] mq[$];
  bit        showing = 0;
  bit        hi      = 0;
  int        tot     = 0;
  bit        mon_en  = 0;
  int        m_sz;
  bit        m_acc, m_pop;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      showing = 0;
      hi      = 0;
      tot     = 0;
    end else begin
      m_sz  = mq.size();
      m_acc = valid_in && (m_sz < DEPTH);
      m_pop = showing && hi && step;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back({flags, result});
        tot++;
      end
      if (!showing) begin
        showing = (m_sz != 0);
        hi      = 0;
      end else if (step) begin
        if (!hi) hi = 1;
        else begin
          hi      = 0;
          showing = (mq.size() != 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("ready_out", 32'(ready_out), 32'(mq.size() != DEPTH));
      chk("disp_en", 32'(disp_en), 32'(showing));
      if (showing && mq.size() != 0) begin
        chk("disp_hi", 32'(disp_hi), 32'(hi));
        chk("disp_data", 32'(disp_data),
            hi ? 32'(mq[0][31:16]) : 32'(mq[0][15:0]));
        chk("disp_flags", 32'(disp_flags), 32'(mq[0][36:32]));
      end else begin
        chk("idle_data", 32'(disp_data), 32'h0);
        chk("idle_flags", 32'(disp_flags), 32'h0);
      end
`ifdef FP_RESULT_BUF_TOTAL_EN
      chk("total", 32'(total), 32'((tot > 255) ? 255 : tot));
`endif
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push1(input logic [31:0] r, input logic [4:0] f);
    valid_in = 1'b1;
    result   = r;
    flags    = f;
    cyc();
    valid_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    step     = 1'b0;
    result   = '0;
    flags    = '0;
    cyc();
    mon_en = 1;
    cyc();
    rst = 1'b0;
    chk("rst_en", 32'(disp_en), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_ready", 32'(ready_out), 32'h1);

    // single entry: low half, high half, then empty
    push1(32'h3F80_0000, 5'd0);
    cyc();
    chk("one_lo_en", 32'(disp_en), 32'h1);
    chk("one_lo_data", 32'(disp_data), 32'h0000);
    chk("one_lo_hi", 32'(disp_hi), 32'h0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("one_hi_data", 32'(disp_data), 32'h3F80);
    chk("one_hi_hi", 32'(disp_hi), 32'h1);
    step = 1'b1; cyc(); step = 1'b0;
    chk("one_done_en", 32'(disp_en), 32'h0);
    chk("one_done_cnt", 32'(count), 32'h0);

    // overfill: fifth push ignored
    for (int i = 1; i <= 5; i++) begin
      valid_in = 1'b1;
      result   = 32'h1000_0000 * i + 32'h0000_0100 * i;
      flags    = 5'(i);
      cyc();
      if (i == 4) chk("full_ready", 32'(ready_out), 32'h0);
    end
    valid_in = 1'b0;
    chk("full_count", 32'(count), 32'h4);
    step = 1'b1; cyc(8); step = 1'b0;
    cyc();
    chk("drain_count", 32'(count), 32'h0);

    // full buffer with valid held across the popping step
    valid_in = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      result = 32'hA000_0000 + 32'(i);
      flags  = 5'(i);
      step   = (i == 5 || i == 6);
      cyc();
    end
    valid_in = 1'b0;
    step     = 1'b0;
    chk("refill_count", 32'(count), 32'h4);
    step = 1'b1; cyc(8); step = 1'b0;
    cyc();

    // flags visible in both halves
    push1(32'h7F80_0000, 5'b00100);
    cyc();
    chk("inf_flags_lo", 32'(disp_flags), 32'h04);
    step = 1'b1; cyc(); step = 1'b0;
    chk("inf_flags_hi", 32'(disp_flags), 32'h04);
    step = 1'b1; cyc(); step = 1'b0;

    // reset while showing high half with three entries held
    for (int i = 0; i < 3; i++) push1(32'hC0DE_0000 + 32'(i), 5'(i));
    step = 1'b1; cyc(); step = 1'b0;
    chk("pre_rst_hi", 32'(disp_hi), 32'h1);
    rst = 1'b1; valid_in = 1'b1; cyc(); rst = 1'b0; valid_in = 1'b0;
    chk("mid_rst_count", 32'(count), 32'h0);
    chk("mid_rst_en", 32'(disp_en), 32'h0);
    chk("mid_rst_ready", 32'(ready_out), 32'h1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      valid_in = 1'($urandom_range(0, 1));
      result   = $urandom;
      flags    = 5'($urandom_range(0, 31));
      step     = ($urandom_range(0, 9) < 4);
      rst      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    valid_in = 1'b0;
    step     = 1'b0;
    rst      = 1'b0;
    cyc(2);

`ifdef FP_RESULT_BUF_TOTAL_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    valid_in = 1'b1;
    step     = 1'b1;
    for (int i = 0; i < 700; i++) begin
      result = $urandom;
      flags  = 5'($urandom_range(0, 31));
      cyc();
    end
    valid_in = 1'b0;
    step     = 1'b0;
    cyc();
    chk("total_sat", 32'(total), 32'd255);
`endif

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_result_buffer.md
FP_RESULT_BUFFER -- requirements
Module: fp_result_buffer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width, equal to log2(DEPTH).

REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- result  in  32  adder result word.
- flags  in  5  adder exception flags.
- valid_in  in  1  result/flags valid this cycle.
- ready_out  out  1  buffer can accept; drives the adder's ready_in.
- step  in  1  single-cycle advance pulse, already debounced.
- disp_data  out  16  halfword presented to the hex display.
- disp_hi  out  1  0 = low half shown, 1 = high half shown.
- disp_flags  out  5  flags of the entry shown.
- disp_en  out  1  display enable; 1 when an entry is shown.
- count  out  AW+1  number of entries held.

Function
REQ-003 Push occurs when valid_in and ready_out are both 1 on a rising edge; {flags, result} is written at the write pointer.
REQ-004 ready_out shall equal (count != DEPTH), combinational from registered count only.
REQ-005 valid_in while ready_out=0 shall be ignored; no data lost or corrupted, count unchanged.
REQ-006 Presentation FSM states: S_EMPTY, S_SHOW_LO, S_SHOW_HI, one-hot encoded.
REQ-007 S_EMPTY -> S_SHOW_LO when count != 0; otherwise stay.
REQ-008 S_SHOW_LO + step -> S_SHOW_HI; S_SHOW_LO without step -> stay.
REQ-009 S_SHOW_HI + step -> pop head; then next state is S_SHOW_LO if count after pop != 0, else S_EMPTY.
REQ-010 step in S_EMPTY shall be ignored.
REQ-011 Outputs in S_SHOW_LO: disp_data = head[15:0], disp_hi=0, disp_en=1.
REQ-012 Outputs in S_SHOW_HI: disp_data = head[31:16], disp_hi=1, disp_en=1.
REQ-013 In both show states disp_flags = head flags; in S_EMPTY disp_data, disp_flags and disp_en shall be 0.
REQ-014 Latency: a push into an empty buffer at edge N shall be displayed (S_SHOW_LO) after edge N+1.
REQ-015 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-016 Pop from full in the same cycle as valid_in: no push that cycle, because ready_out was 0.
REQ-017 Pointers wrap modulo DEPTH; count saturates neither up nor down (guaranteed by REQ-004/009).

Reset
REQ-018 rst=1 at a rising edge shall clear pointers, count and all storage.
REQ-019 On that reset the FSM returns to S_EMPTY; all outputs read 0 except ready_out=1.
REQ-020 Reset mid-display discards all held entries and any concurrent push.

Configuration
REQ-021 With FP_RESULT_BUF_TOTAL_EN defined, add output total (8 bits): count of accepted pushes since reset, saturating at 255.
REQ-022 total shall also add port-level behaviour: it is 0 after reset and increments one cycle after each push.
REQ-023 Without FP_RESULT_BUF_TOTAL_EN, the total port and its counter shall not exist; all other behaviour is identical.

Structure
REQ-024 A shared package fp_pkg shall hold:
- FP_FLAGS_W = 5.
- The entry typedef {flags, result}.
- The FSM state localparams.
REQ-025 One sub-module, sync_fifo (parameterised storage plus pointers/count), shall be instantiated; the presentation FSM and output muxing stay in fp_result_buffer.

Verification
REQ-026 Reset, then push 0x3F800000/flags 0 -> next cycle disp_en=1, disp_data=0x0000, disp_hi=0; after one step disp_data=0x3F80, disp_hi=1; after a second step disp_en=0, count=0.
REQ-027 Push 5 entries back-to-back with no step, DEPTH=4 -> ready_out=0 after 4th accept; 5th ignored; count=4; stepping out 8 times shows entries 1-4 in order.
REQ-028 Full buffer, valid_in held 1 across the popping step -> 5th entry accepted the cycle after the pop, count returns to 4.
REQ-029 Push 0x7F800000 with flags 5'b00100 -> disp_flags=5'b00100 in both S_SHOW_LO and S_SHOW_HI.
REQ-030 Assert rst while in S_SHOW_HI with 3 entries -> next cycle count=0, disp_en=0, ready_out=1, state S_EMPTY.
REQ-031 With FP_RESULT_BUF_TOTAL_EN defined, 300 push/pop pairs -> total=255.
